// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu_pkg: data memory bounds plus the LSU size/state types and size helper.
package riscv_32i_config_pkg;
    localparam int DATA_MEM_DEPTH     = 1024;
    localparam int DATA_MEM_LAST_ADDR = 4095;
endpackage

package riscv_32i_lsu_pkg;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} mem_size_t;
    typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, RESP} lsu_state_t;
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == 2'b00 ? 3'd1 : size == 2'b01 ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: core request/response and data memory port bundle; master is the core/memory side.
interface data_mem_lsu_if #(parameter int AW = $clog2(riscv_32i_config_pkg::DATA_MEM_DEPTH));
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    modport master(
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_addr, mem_we, mem_wdata
    );
    modport slave(
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/data_mem_lsu_load_align.sv
// lsu_load_align: extracts a byte/half/word from a two-word window and sign/zero extends it.
module lsu_load_align
    import riscv_32i_lsu_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [1:0]  i_off,
    input  mem_size_t   i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);
    logic [31:0] w_sh;
    logic        w_sign_b;
    logic        w_sign_h;
    assign w_sh     = 32'(i_data >> {i_off, 3'b000});
    assign w_sign_b = ~i_unsigned & w_sh[7];
    assign w_sign_h = ~i_unsigned & w_sh[15];
    assign o_data   = i_size == BYTE ? {{24{w_sign_b}}, w_sh[7:0]} :
                      i_size == HALF ? {{16{w_sign_h}}, w_sh[15:0]} : w_sh;
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte/half/word load-store unit with bounds checking and word-boundary splitting.
module data_mem_lsu
    import riscv_32i_lsu_pkg::*;
#(
    parameter int DEPTH     = riscv_32i_config_pkg::DATA_MEM_DEPTH,
    parameter int LAST_ADDR = riscv_32i_config_pkg::DATA_MEM_LAST_ADDR
)(
    input logic          clk,
    input logic          rst,
    data_mem_lsu_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    lsu_state_t    r_state;
    logic [AW+1:0] r_addr;
    mem_size_t     r_size;
    logic          r_we;
    logic          r_uns;
    logic          r_split;
    logic          r_err;
    logic [31:0]   r_wdata;
    logic [31:0]   r_lo;
    logic [31:0]   r_rslt;
    logic [2:0]    w_req_n;
    logic [32:0]   w_end;
    logic          w_err;
    logic          w_split;
    logic [2:0]    w_n;
    logic [7:0]    w_mask8;
    logic [63:0]   w_wd64;
    logic [AW-1:0] w_idx;
    logic          w_lo;
    logic          w_hi;
    logic [31:0]   w_load;
    // End address is formed 33 bits wide so a request near 0xFFFFFFFF cannot wrap into range.
    assign w_req_n = size_bytes(bus.req_size);
    assign w_end   = {1'b0, bus.req_addr} + {30'b0, w_req_n} - 33'd1;
    assign w_err   = bus.req_size == 2'b11 || w_end > 33'(LAST_ADDR);
    assign w_split = {1'b0, bus.req_addr[1:0]} + w_req_n > 3'd4;
    assign w_n     = size_bytes(r_size);
    assign w_mask8 = ((8'd1 << w_n) - 8'd1) << r_addr[1:0];
    assign w_wd64  = {32'b0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_idx   = r_addr[AW+1:2];
    assign w_lo    = !rst && r_state == ACC_LO;
    assign w_hi    = !rst && r_state == ACC_HI;
    assign bus.req_ready = !rst && r_state == IDLE;
    assign bus.rsp_valid = !rst && r_state == RESP;
    assign bus.rsp_err   = bus.rsp_valid && r_err;
    assign bus.rsp_rdata = bus.rsp_valid ? r_rslt : 32'b0;
    assign bus.mem_en    = w_lo || w_hi;
    assign bus.mem_addr  = w_lo ? w_idx : w_hi ? w_idx + AW'(1) : '0;
    assign bus.mem_we    = !r_we ? 4'b0 : w_lo ? w_mask8[3:0] : w_hi ? w_mask8[7:4] : 4'b0;
    assign bus.mem_wdata = !r_we ? 32'b0 : w_lo ? w_wd64[31:0] : w_hi ? w_wd64[63:32] : 32'b0;
    lsu_load_align u_align (
        .i_data     (r_split ? {bus.mem_rdata, r_lo} : {32'b0, bus.mem_rdata}),
        .i_off      (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_load)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_size  <= BYTE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_rslt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_addr  <= bus.req_addr[AW+1:0];
                    r_size  <= w_err ? BYTE : mem_size_t'(bus.req_size);
                    r_we    <= bus.req_we;
                    r_uns   <= bus.req_unsigned;
                    r_split <= w_split;
                    r_err   <= w_err;
                    r_wdata <= bus.req_wdata;
                    r_rslt  <= '0;
                    r_state <= w_err ? RESP : ACC_LO;
                end
                ACC_LO: r_state <= r_split ? ACC_HI : r_we ? RESP : WAIT;
                ACC_HI: begin
                    r_lo    <= bus.mem_rdata;
                    r_state <= r_we ? RESP : WAIT;
                end
                WAIT: begin
                    r_rslt  <= w_load;
                    r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed vectors against data_mem_lsu with a behavioural data memory.
module tb_data_mem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] mem [1024];
    data_mem_lsu_if #(.AW(10)) bus();
    data_mem_lsu dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        for (int i = 0; i < 10 && !bus.req_ready; i++) tick();
        if (!bus.req_ready) chk("ready timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        tick();
        bus.req_valid = 1'b0;
    endtask
    task automatic await_rsp(input string tag, input int k0, input int lat,
                             input logic [31:0] rd, input logic err);
        int k = k0;
        int n_en = 0;
        while (!bus.rsp_valid && k < 12) begin
            n_en += int'(bus.mem_en);
            tick();
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " rdata"}, bus.rsp_rdata, rd);
        chk({tag, " err"}, 32'(bus.rsp_err), 32'(err));
        if (err) chk({tag, " mem_en count"}, 32'(n_en), 32'd0);
    endtask
    task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int lat,
                      input logic [31:0] rd, input logic err);
        send(we, sz, uns, addr, wd);
        await_rsp(tag, 1, lat, rd, err);
    endtask
    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        tick();
        tick();
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset mem_en", 32'(bus.mem_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready after reset", 32'(bus.req_ready), 32'd1);
        send(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
        chk("sw mem_en", 32'(bus.mem_en), 32'd1);
        chk("sw mem_addr", 32'(bus.mem_addr), 32'd4);
        chk("sw mem_we", 32'(bus.mem_we), 32'hF);
        await_rsp("sw 0x010", 1, 2, 32'h0, 1'b0);
        op("lw 0x010", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        op("lb 0x011", 1'b0, 2'b00, 1'b0, 32'h011, 32'h0, 3, 32'hFFFFFFBE, 1'b0);
        op("lbu 0x011", 1'b0, 2'b00, 1'b1, 32'h011, 32'h0, 3, 32'h000000BE, 1'b0);
        op("lh 0x012", 1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 3, 32'hFFFFDEAD, 1'b0);
        op("lhu 0x012", 1'b0, 2'b01, 1'b1, 32'h012, 32'h0, 3, 32'h0000DEAD, 1'b0);
        send(1'b1, 2'b10, 1'b0, 32'h00E, 32'h11223344);
        chk("split lo addr", 32'(bus.mem_addr), 32'd3);
        chk("split lo we", 32'(bus.mem_we), 32'hC);
        chk("split lo wdata", bus.mem_wdata, 32'h33440000);
        tick();
        chk("split hi addr", 32'(bus.mem_addr), 32'd4);
        chk("split hi we", 32'(bus.mem_we), 32'h3);
        chk("split hi wdata", bus.mem_wdata, 32'h00001122);
        await_rsp("split sw 0x00E", 2, 3, 32'h0, 1'b0);
        op("split lw 0x00E", 1'b0, 2'b10, 1'b0, 32'h00E, 32'h0, 4, 32'h11223344, 1'b0);
        op("lw 0x010 merged", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 3, 32'hDEAD1122, 1'b0);
        op("sw 0xFFC", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, 2, 32'h0, 1'b0);
        op("lw 0xFFC", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 3, 32'hCAFEF00D, 1'b0);
        op("lb 0xFFF", 1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0, 3, 32'hFFFFFFCA, 1'b0);
        op("lw 0xFFD", 1'b0, 2'b10, 1'b0, 32'hFFD, 32'h0, 1, 32'h0, 1'b1);
        op("sb 0x1000", 1'b1, 2'b00, 1'b0, 32'h1000, 32'hFF, 1, 32'h0, 1'b1);
        op("lh 0xFFFFFFFF", 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1'b1);
        op("size 11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1);
        op("sw 0x01C", 1'b1, 2'b10, 1'b0, 32'h01C, 32'hAAAAAAAA, 2, 32'h0, 1'b0);
        op("sw 0x020", 1'b1, 2'b10, 1'b0, 32'h020, 32'hBBBBBBBB, 2, 32'h0, 1'b0);
        send(1'b1, 2'b10, 1'b0, 32'h01E, 32'h55667788);
        tick();
        rst = 1'b1;
        #1;
        chk("abort mem_en", 32'(bus.mem_en), 32'd0);
        chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort ready after release", 32'(bus.req_ready), 32'd1);
        chk("abort no rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("abort still no rsp", 32'(bus.rsp_valid), 32'd0);
        op("lw 0x01C after abort", 1'b0, 2'b10, 1'b0, 32'h01C, 32'h0, 3, 32'h7788AAAA, 1'b0);
        op("lw 0x020 after abort", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 3, 32'hBBBBBBBB, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
